fa_exerciser: RTL and testbench
===============================

# fa_exerciser

Sequential stimulus/response engine that drives the other end of the `fuladd` full-adder interface. It owns `a`, `b` and `ci`, and samples `s` and `cry`. On a start pulse it sweeps all eight input vectors for a configurable number of passes and compares each response against the arithmetic sum. It reports an error count, a sticky fail flag and the first failing vector. It sits beside any `fuladd`-compatible adder instance as an on-chip self-test block.

## Interface
Parameters:
- `SETTLE`, default 1: extra cycles each vector is held before its response is sampled; range 0..15.
- `PASSES`, default 1: number of full 8-vector sweeps per run; range 1..255.
- `ERRW`, default 8: width of the error counter.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: run request; accepted only in IDLE.
- `busy` out 1: high while vectors are being applied.
- `done` out 1: one-cycle pulse at end of run.
- `a`, `b`, `ci` out 1 each: registered stimulus to the adder.
- `s`, `cry` in 1 each: adder response.
- `err_cnt` out ERRW: number of mismatching samples in the current or last run; saturating.
- `fail` out 1: sticky; set by any mismatch in the run.
- `first_err_vec` out 3: `{a,b,ci}` of the first mismatch.
- `first_err_valid` out 1: `first_err_vec` holds a captured value.

## Operation
- FSM states: IDLE, APPLY, DONE.
- **IDLE**:
  - `busy`=0, `done`=0.
  - `start`=1 moves to APPLY.
  - Acceptance sets vector index `vec`=0 and pass counter=0.
  - Acceptance clears `err_cnt`, `fail`, `first_err_vec` and `first_err_valid`.
- **APPLY**:
  - `{a,b,ci}` = `vec`, with `a` as the MSB.
  - A hold counter runs 0..SETTLE.
  - On the edge where hold = SETTLE, `{cry,s}` is compared with expected = a+b+ci, a 2-bit zero-extended sum.
  - On mismatch: `err_cnt` increments, saturating at 2^ERRW−1, and `fail` is set.
  - On the first mismatch of the run only, `{a,b,ci}` is captured into `first_err_vec` and `first_err_valid` is set.
  - The same edge advances `vec`; it wraps from 7 to 0 and then increments the pass counter.
  - After vector 7 of pass PASSES−1, the FSM goes to DONE.
- **DONE**: `done`=1 for exactly one cycle, `{a,b,ci}` returns to 0, then back to IDLE.
- `start` in APPLY or DONE is ignored; it is neither queued nor a restart.
- Result outputs hold their values after DONE until the next accepted start or reset.
- Reset mid-run: the run is aborted silently, with no `done` pulse and results cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `a`=`b`=`ci`=0, `err_cnt`=0, `fail`=0, `first_err_vec`=0, `first_err_valid`=0; FSM in IDLE.
- `start` sampled high at edge k gives `busy`=1 and vector 0 on `{a,b,ci}` from cycle k+1.
- Each vector is held for SETTLE+1 cycles. With SETTLE=0 the response is sampled in the same cycle the vector is applied.
- `busy` lasts exactly 8·PASSES·(SETTLE+1) cycles.
- `done` is high in cycle k+1+8·PASSES·(SETTLE+1).
- Final `err_cnt`, `fail` and `first_err_*` are valid in the same cycle as `done`.
- Earliest re-accept: `start` high in the cycle after `done`. Holding `start` high gives back-to-back runs separated by one IDLE cycle.
- `s` and `cry` are sampled only at compare edges; values at other edges have no effect.

## Test plan
1. Correct adder, SETTLE=1, PASSES=1, single `start` pulse at edge k:
   - `busy` high 16 cycles; `done` pulse in cycle k+17.
   - `err_cnt`=0, `fail`=0, `first_err_valid`=0.
2. Adder with `cry` stuck at 0, defaults:
   - `err_cnt`=4 (vectors 3,5,6,7), `fail`=1.
   - `first_err_vec`=3'b011, `first_err_valid`=1.
3. Adder with inverted `s`, PASSES=2, SETTLE=0:
   - `busy` 16 cycles, `err_cnt`=16, `first_err_vec`=3'b000.
4. Same fault with ERRW=2:
   - `err_cnt` saturates at 3; `fail`=1.
5. Reset asserted while `vec`=4 in pass 0:
   - Next cycle all outputs at reset values, no `done`.
   - A following `start` sweeps from vector 0, giving the full run length and counts as in scenario 1.
6. `start` pulsed during APPLY and during DONE:
   - Ignored; run length unchanged, single `done`.
   - With `start` held high, runs repeat with one IDLE cycle between and `err_cnt` cleared at each acceptance.

Source files
------------

// File: rtl/fa_exerciser.sv
// fa_exerciser: on-chip self-test engine for a fuladd-compatible full adder.
// Sweeps all eight {a,b,ci} vectors for PASSES passes, holding each one
// SETTLE+1 cycles, and compares {cry,s} with the arithmetic sum.
//
// Ports:
//   clk             - clock, all state on rising edge
//   rst             - synchronous active-high reset
//   start           - run request, accepted only in idle
//   busy            - high while vectors are applied
//   done            - one-cycle pulse at end of run
//   a, b, ci        - registered stimulus to the adder
//   s, cry          - adder response
//   err_cnt         - saturating mismatch count of current/last run
//   fail            - sticky mismatch flag for the run
//   first_err_vec   - {a,b,ci} of the first mismatch
//   first_err_valid - first_err_vec holds a captured value
module fa_exerciser #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERRW   = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            a,
  output logic            b,
  output logic            ci,
  input  logic            s,
  input  logic            cry,
  output logic [ERRW-1:0] err_cnt,
  output logic            fail,
  output logic [2:0]      first_err_vec,
  output logic            first_err_valid
);

  localparam logic [3:0] SettleLast = 4'(SETTLE);
  localparam logic [7:0] PassLast   = 8'(PASSES - 1);

  typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        vec_q, vec_d;
  logic [7:0]        pass_q, pass_d;
  logic [3:0]        hold_q, hold_d;
  logic [ERRW-1:0]   err_q, err_d;
  logic              fail_q, fail_d;
  logic [2:0]        fev_q, fev_d;
  logic              fv_q, fv_d;
  logic [1:0]        exp_sum;

  assign exp_sum = 2'(vec_q[2]) + 2'(vec_q[1]) + 2'(vec_q[0]);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    pass_d  = pass_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fail_d  = fail_q;
    fev_d   = fev_q;
    fv_d    = fv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StApply;
          vec_d   = 3'd0;
          pass_d  = 8'd0;
          hold_d  = 4'd0;
          err_d   = '0;
          fail_d  = 1'b0;
          fev_d   = 3'd0;
          fv_d    = 1'b0;
        end
      end
      StApply: begin
        if (hold_q == SettleLast) begin
          hold_d = 4'd0;
          if ({cry, s} != exp_sum) begin
            if (err_q != {ERRW{1'b1}}) err_d = err_q + 1'b1;
            fail_d = 1'b1;
            if (!fv_q) begin
              fev_d = vec_q;
              fv_d  = 1'b1;
            end
          end
          // vec wraps 7 -> 0, so stimulus is already zero on entry to done
          vec_d = vec_q + 3'd1;
          if (vec_q == 3'd7) begin
            if (pass_q == PassLast) state_d = StDone;
            else                    pass_d  = pass_q + 8'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= 3'd0;
      pass_q  <= 8'd0;
      hold_q  <= 4'd0;
      err_q   <= '0;
      fail_q  <= 1'b0;
      fev_q   <= 3'd0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      fev_q   <= fev_d;
      fv_q    <= fv_d;
    end
  end

  assign busy            = (state_q == StApply);
  assign done            = (state_q == StDone);
  assign a               = vec_q[2];
  assign b               = vec_q[1];
  assign ci              = vec_q[0];
  assign err_cnt         = err_q;
  assign fail            = fail_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fv_q;

endmodule

// File: tb/tb_fa_exerciser.sv
// Bench for fa_exerciser: three instances with different SETTLE/PASSES/ERRW,
// each driving a behavioural adder with a selectable fault. Expected run
// results are queued at start and checked when done pulses.
module tb_fa_exerciser;

  typedef struct {
    int d;
    int err;
    int fail;
    int fev;
    int fv;
    int blen;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_r [3];
  int         fault_r [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic       a_w     [3];
  logic       b_w     [3];
  logic       ci_w    [3];
  logic       s_w     [3];
  logic       cry_w   [3];
  logic       fail_w  [3];
  logic       fv_w    [3];
  logic [2:0] fev_w   [3];
  logic [7:0] err0, err1;
  logic [1:0] err2;
  int         err_v   [3];
  logic [2:0] vec_w   [3];

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   busy_cnt  [3];
  logic done_prev [3];
  logic busy_prev [3];

  always #5 clk = ~clk;

  // 0: fault-free, 1: cry stuck at 0, 2: s inverted
  function automatic logic [1:0] adder_resp(input int fault, input logic [2:0] v);
    logic [1:0] r;
    r = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
    if (fault == 1) r[1] = 1'b0;
    if (fault == 2) r[0] = ~r[0];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      vec_w[i] = {a_w[i], b_w[i], ci_w[i]};
      {cry_w[i], s_w[i]} = adder_resp(fault_r[i], vec_w[i]);
    end
    err_v[0] = int'(err0);
    err_v[1] = int'(err1);
    err_v[2] = int'(err2);
  end

  fa_exerciser #(.SETTLE(1), .PASSES(1), .ERRW(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .a(a_w[0]), .b(b_w[0]), .ci(ci_w[0]), .s(s_w[0]), .cry(cry_w[0]), .err_cnt(err0),
    .fail(fail_w[0]), .first_err_vec(fev_w[0]), .first_err_valid(fv_w[0])
  );

  fa_exerciser #(.SETTLE(0), .PASSES(2), .ERRW(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .a(a_w[1]), .b(b_w[1]), .ci(ci_w[1]), .s(s_w[1]), .cry(cry_w[1]), .err_cnt(err1),
    .fail(fail_w[1]), .first_err_vec(fev_w[1]), .first_err_valid(fv_w[1])
  );

  fa_exerciser #(.SETTLE(0), .PASSES(2), .ERRW(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_r[2]), .busy(busy_w[2]), .done(done_w[2]),
    .a(a_w[2]), .b(b_w[2]), .ci(ci_w[2]), .s(s_w[2]), .cry(cry_w[2]), .err_cnt(err2),
    .fail(fail_w[2]), .first_err_vec(fev_w[2]), .first_err_valid(fv_w[2])
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic int passes_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic int errw_of(input int d);
    return (d == 2) ? 2 : 8;
  endfunction

  function automatic exp_t model(input int d, input int fault);
    exp_t e;
    e.d    = d;
    e.err  = 0;
    e.fail = 0;
    e.fev  = 0;
    e.fv   = 0;
    e.blen = 8 * passes_of(d) * (settle_of(d) + 1);
    for (int p = 0; p < passes_of(d); p++) begin
      for (int v = 0; v < 8; v++) begin
        logic [2:0] vv;
        vv = 3'(v);
        if (int'(adder_resp(fault, vv)) != $countones(vv)) begin
          if (e.err < (1 << errw_of(d)) - 1) e.err++;
          e.fail = 1;
          if (e.fv == 0) begin
            e.fev = v;
            e.fv  = 1;
          end
        end
      end
    end
    return e;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        busy_cnt[i] = 0;
      end else begin
        if (done_w[i]) begin
          check_eq("done_single_cycle", int'(done_prev[i]), 0);
          check_eq("done_after_busy", int'(busy_prev[i]), 1);
          check_eq("done_expected", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("sb_dut", i, e.d);
            check_eq("err_cnt", err_v[i], e.err);
            check_eq("fail", int'(fail_w[i]), e.fail);
            check_eq("first_err_vec", int'(fev_w[i]), e.fev);
            check_eq("first_err_valid", int'(fv_w[i]), e.fv);
            check_eq("busy_len", busy_cnt[i], e.blen);
            check_eq("vec_zero_at_done", int'(vec_w[i]), 0);
          end
          busy_cnt[i] = 0;
        end
        if (busy_w[i]) busy_cnt[i]++;
      end
      done_prev[i] = done_w[i];
      busy_prev[i] = busy_w[i];
    end
  end

  task automatic start_run(input int d, input int fault);
    fault_r[d] = fault;
    sb_q.push_back(model(d, fault));
    start_r[d] = 1'b1;
    @(negedge clk);
    check_eq("busy_first_cycle", int'(busy_w[d]), 1);
    check_eq("vec0_first_cycle", int'(vec_w[d]), 0);
    start_r[d] = 1'b0;
  endtask

  // Returns on the falling edge inside the done cycle
  task automatic wait_done(input int d, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_w[d]) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("wait_done", int'(seen), 1);
  endtask

  initial begin
    int  bcount;
    bit  found;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_r[i]   = 1'b0;
      fault_r[i]   = 0;
      busy_cnt[i]  = 0;
      done_prev[i] = 1'b0;
      busy_prev[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(busy_w[0]), 0);
    check_eq("rst_done", int'(done_w[0]), 0);
    check_eq("rst_vec", int'(vec_w[0]), 0);
    check_eq("rst_err", err_v[0], 0);
    check_eq("rst_fail", int'(fail_w[0]), 0);
    check_eq("rst_fev", int'(fev_w[0]), 0);
    check_eq("rst_fv", int'(fv_w[0]), 0);
    rst = 1'b0;
    @(negedge clk);

    // Fault-free, SETTLE=1 PASSES=1
    start_run(0, 0);
    wait_done(0, 40);
    @(negedge clk);

    // cry stuck at 0
    start_run(0, 1);
    wait_done(0, 40);
    @(negedge clk);

    // s inverted, PASSES=2 SETTLE=0
    start_run(1, 2);
    wait_done(1, 40);
    @(negedge clk);

    // same fault, 2-bit counter saturates
    start_run(2, 2);
    wait_done(2, 40);
    @(negedge clk);

    // Reset mid-run at vector 4 of pass 0
    start_run(0, 1);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy_w[0] && vec_w[0] == 3'd4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("reached_vec4", int'(found), 1);
    check_eq("err_before_abort", err_v[0], 1);
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check_eq("abort_busy", int'(busy_w[0]), 0);
    check_eq("abort_done", int'(done_w[0]), 0);
    check_eq("abort_vec", int'(vec_w[0]), 0);
    check_eq("abort_err", err_v[0], 0);
    check_eq("abort_fail", int'(fail_w[0]), 0);
    check_eq("abort_fev", int'(fev_w[0]), 0);
    check_eq("abort_fv", int'(fv_w[0]), 0);
    rst = 1'b0;
    start_run(0, 0);
    wait_done(0, 40);
    @(negedge clk);

    // start during APPLY and during DONE is ignored
    start_run(0, 0);
    repeat (5) @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_done(0, 40);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    bcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_w[0] || done_w[0]) bcount++;
      @(negedge clk);
    end
    check_eq("no_restart", bcount, 0);

    // start held high: back-to-back runs with one idle cycle between
    fault_r[0] = 1;
    sb_q.push_back(model(0, 1));
    sb_q.push_back(model(0, 1));
    start_r[0] = 1'b1;
    wait_done(0, 40);
    @(negedge clk);
    check_eq("gap_idle_busy", int'(busy_w[0]), 0);
    check_eq("gap_idle_done", int'(done_w[0]), 0);
    @(negedge clk);
    check_eq("rerun_busy", int'(busy_w[0]), 1);
    start_r[0] = 1'b0;
    wait_done(0, 40);
    repeat (5) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
